uart_rx_controller: RTL and testbench
=====================================

UART_RX_CONTROLLER -- requirements
Module: uart_rx_controller

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, receive-FIFO entries; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cfg_enable  input  1  host request to run the receiver.
REQ-005 cfg_baud_select  input  3  requested baud code.
REQ-006 baud_select  output  3  baud code applied to the receiver.
REQ-007 RX_EN  output  1  receiver enable.
REQ-008 Rx_DATA  input  8  received byte, valid when Rx_VALID=1.
REQ-009 Rx_VALID  input  1  one-cycle pulse, good frame.
REQ-010 Rx_FERROR  input  1  one-cycle pulse, framing error.
REQ-011 Rx_PERROR  input  1  one-cycle pulse, parity error.
REQ-012 out_data  output  8  FIFO head byte.
REQ-013 out_valid  output  1  FIFO non-empty.
REQ-014 out_ready  input  1  consumer accepts head.
REQ-015 fifo_count  output  $clog2(FIFO_DEPTH)+1  occupancy.
REQ-016 overrun  output  1  sticky: a good byte was dropped because the FIFO was full.
REQ-017 err_clear  input  1  one-cycle pulse; clears overrun and error counters.
REQ-018 ferr_count, perr_count  output  8 each  saturating error counters.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, SETTLE and RUN; RX_EN SHALL be 1 only in RUN.
REQ-020 IDLE->LOAD SHALL occur when cfg_enable=1; LOAD SHALL latch cfg_baud_select into baud_select and go to SETTLE in 1 cycle.
REQ-021 SETTLE SHALL last exactly 2 cycles with RX_EN=0, then go to RUN; cfg_enable=0 in LOAD or SETTLE SHALL go to IDLE.
REQ-022 In RUN, cfg_enable=0 SHALL go to IDLE; cfg_baud_select != baud_select SHALL go to LOAD. In both cases RX_EN SHALL drop the next cycle.
REQ-023 baud_select SHALL change only in LOAD.
REQ-024 Rx_VALID/Rx_FERROR/Rx_PERROR SHALL be ignored outside RUN, including the cycle RUN is exited.
REQ-025 Rx_VALID in RUN SHALL push Rx_DATA; out_valid SHALL assert the cycle after the push (latency 1).
REQ-026 Rx_VALID coincident with Rx_FERROR or Rx_PERROR SHALL NOT push.
REQ-027 Pop SHALL occur when out_valid=1 and out_ready=1; out_data SHALL then show the next entry in the following cycle.
REQ-028 Push when full without a same-cycle pop SHALL drop the byte, leave the FIFO unchanged and set overrun.
REQ-029 Push and pop in the same cycle SHALL both succeed at any occupancy, including full; fifo_count SHALL be unchanged.
REQ-030 Pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL never exceed FIFO_DEPTH.
REQ-031 Leaving RUN SHALL NOT flush the FIFO; the consumer SHALL be able to drain it in any state.
REQ-032 err_clear SHALL take priority over a same-cycle error or overrun event, and that event SHALL be lost.

Reset
REQ-033 While reset=1, the block SHALL force the following, in IDLE state, on the next clk edge: RX_EN=0, baud_select=3'b000, FIFO empty, fifo_count=0, out_valid=0, out_data=8'h00, overrun=0, ferr_count=0, perr_count=0.
REQ-034 Reset mid-frame or mid-drain SHALL discard all FIFO contents without popping them.

Configuration
REQ-035 Macro UART_RXC_ERR_COUNT_EN: when defined, Rx_FERROR in RUN SHALL increment ferr_count and Rx_PERROR in RUN SHALL increment perr_count; both counters SHALL saturate at 8'hFF. Both flags together SHALL increment both counters.
REQ-036 Without UART_RXC_ERR_COUNT_EN, ferr_count and perr_count SHALL remain ports, tied to 8'h00; all other behaviour SHALL be unchanged.

Verification
REQ-037 Reset, cfg_enable=1, cfg_baud_select=3'b101 -> LOAD at cycle 1, SETTLE cycles 2-3, RX_EN=1 from cycle 4, baud_select=3'b101.
REQ-038 In RUN, pulse Rx_VALID with bytes 8'hA5, 8'h3C, 8'h00, 8'hFF, out_ready=0 -> fifo_count=4; a 5th byte 8'h11 -> overrun=1, 8'h11 absent; 4 pops return A5,3C,00,FF.
REQ-039 FIFO full, Rx_VALID=1 with 8'h77 and out_ready=1 in the same cycle -> head popped, 8'h77 stored, fifo_count stays 4, overrun stays 0.
REQ-040 In RUN, change cfg_baud_select to 3'b010 -> RX_EN=0 next cycle; a Rx_VALID pulse during SETTLE is not pushed; RX_EN=1 again after 2 SETTLE cycles with baud_select=3'b010.
REQ-041 With macro defined: 300 Rx_FERROR pulses -> ferr_count=8'hFF; err_clear together with a Rx_PERROR pulse -> perr_count=0. Without the macro: both counters read 0 throughout.
REQ-042 Reset asserted with fifo_count=3 -> next cycle out_valid=0, fifo_count=0, FSM in IDLE, RX_EN=0.

Source files
------------

// File: rtl/uart_rx_controller.sv
// -----------------------------------------------------------------------------
// uart_rx_controller
//
// Control and buffering layer that sits between a host and a UART receiver
// core. It sequences the receiver through a configuration handshake
// (IDLE -> LOAD -> SETTLE -> RUN), buffers good bytes in a small receive
// FIFO, tracks dropped bytes with a sticky overrun flag, and optionally
// counts framing and parity errors.
//
// Optional feature:
//   UART_RXC_ERR_COUNT_EN  -- when defined, ferr_count / perr_count are
//                             saturating 8-bit error counters. When not
//                             defined, both ports are tied to 8'h00.
//
// Parameters:
//   FIFO_DEPTH       receive FIFO entries, power of two in 2..16 (default 4)
//
// Ports:
//   clk              system clock, all logic on its rising edge
//   reset            synchronous active-high reset
//   cfg_enable       host request to run the receiver
//   cfg_baud_select  requested baud code
//   baud_select      baud code applied to the receiver (changes only in LOAD)
//   RX_EN            receiver enable, high only in RUN
//   Rx_DATA          received byte, qualified by Rx_VALID
//   Rx_VALID         one-cycle pulse, good frame
//   Rx_FERROR        one-cycle pulse, framing error
//   Rx_PERROR        one-cycle pulse, parity error
//   out_data         FIFO head byte (8'h00 when empty)
//   out_valid        FIFO non-empty
//   out_ready        consumer accepts the head byte
//   fifo_count       FIFO occupancy, 0..FIFO_DEPTH
//   overrun          sticky: a good byte was dropped because the FIFO was full
//   err_clear        one-cycle pulse; clears overrun and error counters
//   ferr_count       saturating framing-error counter
//   perr_count       saturating parity-error counter
// -----------------------------------------------------------------------------
module uart_rx_controller #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_enable,
  input  logic [2:0]                    cfg_baud_select,
  output logic [2:0]                    baud_select,
  output logic                          RX_EN,
  input  logic [7:0]                    Rx_DATA,
  input  logic                          Rx_VALID,
  input  logic                          Rx_FERROR,
  input  logic                          Rx_PERROR,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  input  logic                          err_clear,
  output logic [7:0]                    ferr_count,
  output logic [7:0]                    perr_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Configuration sequencer
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } state_t;

  state_t state;
  logic   settle_cnt;   // 0 = first SETTLE cycle, 1 = second (last) one

  // NOTE: sequential state is always written with non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      settle_cnt  <= 1'b0;
      RX_EN       <= 1'b0;
      baud_select <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          RX_EN <= 1'b0;
          if (cfg_enable) state <= LOAD;
        end

        LOAD: begin
          // The only place the applied baud code may change.
          baud_select <= cfg_baud_select;
          settle_cnt  <= 1'b0;
          RX_EN       <= 1'b0;
          state       <= cfg_enable ? SETTLE : IDLE;
        end

        SETTLE: begin
          if (!cfg_enable) begin
            state <= IDLE;
            RX_EN <= 1'b0;
          end else if (settle_cnt) begin
            // RX_EN is registered together with the state so it is high in
            // exactly the cycles the FSM is in RUN.
            state <= RUN;
            RX_EN <= 1'b1;
          end else begin
            settle_cnt <= 1'b1;
          end
        end

        RUN: begin
          if (!cfg_enable) begin
            state <= IDLE;
            RX_EN <= 1'b0;
          end else if (cfg_baud_select != baud_select) begin
            state <= LOAD;
            RX_EN <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          RX_EN <= 1'b0;
        end
      endcase
    end
  end

  // Receiver events are only honoured in RUN cycles that are not themselves
  // exiting RUN, so a pulse arriving in the exit cycle is dropped as well.
  logic run_active;
  assign run_active = (state == RUN) && cfg_enable &&
                      (cfg_baud_select == baud_select);

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic full;
  logic push_req;
  logic push_ok;
  logic pop;

  assign full      = (count == FULL_COUNT);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;

  // A byte flagged with any error in the same cycle is never stored.
  assign push_req  = run_active && Rx_VALID && !Rx_FERROR && !Rx_PERROR;

  // A same-cycle pop frees the slot, so push succeeds even when full.
  assign push_ok   = push_req && (!full || pop);

  // NOTE: the storage array carries no reset; emptiness is tracked purely by
  // the pointers and count, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= Rx_DATA;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // FIFO_DEPTH is a power of two, so natural pointer overflow is the
      // modulo-FIFO_DEPTH wrap.
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head byte is masked while empty so it reads 8'h00 after reset without
  // having to clear the storage array.
  assign out_data   = out_valid ? mem[rd_ptr] : 8'h00;
  assign fifo_count = count;

  // ---------------------------------------------------------------------------
  // Overrun flag: err_clear wins over a same-cycle drop, which is then lost.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (err_clear) begin
      overrun <= 1'b0;
    end else if (push_req && full && !pop) begin
      overrun <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Error counters
  // ---------------------------------------------------------------------------
`ifdef UART_RXC_ERR_COUNT_EN
  logic [7:0] ferr_q;
  logic [7:0] perr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ferr_q <= 8'h00;
      perr_q <= 8'h00;
    end else if (err_clear) begin
      ferr_q <= 8'h00;
      perr_q <= 8'h00;
    end else begin
      // Both flags together bump both counters; each holds at 8'hFF.
      if (run_active && Rx_FERROR && (ferr_q != 8'hFF)) ferr_q <= ferr_q + 8'd1;
      if (run_active && Rx_PERROR && (perr_q != 8'hFF)) perr_q <= perr_q + 8'd1;
    end
  end

  assign ferr_count = ferr_q;
  assign perr_count = perr_q;
`else
  assign ferr_count = 8'h00;
  assign perr_count = 8'h00;
`endif

endmodule

// File: tb/tb_uart_rx_controller.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_controller
//
// Directed bench for uart_rx_controller. Stimulus pushes every byte it expects
// to come out of the FIFO into a scoreboard queue; a monitor process pops and
// compares whenever the DUT hands a byte to the consumer. Point checks on
// control outputs go through check().
// -----------------------------------------------------------------------------
module tb_uart_rx_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_enable;
  logic [2:0] cfg_baud_select;
  logic [2:0] baud_select;
  logic       RX_EN;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_FERROR;
  logic       Rx_PERROR;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] fifo_count;
  logic       overrun;
  logic       err_clear;
  logic [7:0] ferr_count;
  logic [7:0] perr_count;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] exp_q [$];

  uart_rx_controller #(.FIFO_DEPTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .cfg_enable      (cfg_enable),
    .cfg_baud_select (cfg_baud_select),
    .baud_select     (baud_select),
    .RX_EN           (RX_EN),
    .Rx_DATA         (Rx_DATA),
    .Rx_VALID        (Rx_VALID),
    .Rx_FERROR       (Rx_FERROR),
    .Rx_PERROR       (Rx_PERROR),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .fifo_count      (fifo_count),
    .overrun         (overrun),
    .err_clear       (err_clear),
    .ferr_count      (ferr_count),
    .perr_count      (perr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are then stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit stored);
    Rx_DATA  = b;
    Rx_VALID = 1'b1;
    if (stored) exp_q.push_back(b);
    tick();
    Rx_VALID = 1'b0;
  endtask

  // Monitor: a transfer happens at the next rising edge when out_valid and
  // out_ready are both high; sample mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pop_unexpected: got 0x%0h, expected no output", out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          miscompares++;
          $display("FAIL pop_data: got 0x%0h, expected 0x%0h", out_data, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    cfg_enable      = 1'b0;
    cfg_baud_select = 3'b000;
    Rx_DATA         = 8'h00;
    Rx_VALID        = 1'b0;
    Rx_FERROR       = 1'b0;
    Rx_PERROR       = 1'b0;
    out_ready       = 1'b0;
    err_clear       = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_rx_en",   RX_EN,       0);
    check("rst_baud",    baud_select, 0);
    check("rst_count",   fifo_count,  0);
    check("rst_valid",   out_valid,   0);
    check("rst_data",    out_data,    0);
    check("rst_overrun", overrun,     0);
    check("rst_ferr",    ferr_count,  0);
    check("rst_perr",    perr_count,  0);

    // Bring-up: LOAD at cycle 1, SETTLE 2-3, RUN from 4
    reset           = 1'b0;
    cfg_enable      = 1'b1;
    cfg_baud_select = 3'b101;
    tick();
    check("c1_load_rx_en", RX_EN, 0);
    check("c1_baud_hold",  baud_select, 0);
    tick();
    check("c2_settle_rx_en", RX_EN, 0);
    check("c2_baud",         baud_select, 3'b101);
    tick();
    check("c3_settle_rx_en", RX_EN, 0);
    tick();
    check("c4_run_rx_en", RX_EN, 1);
    check("c4_baud",      baud_select, 3'b101);

    // Fill, overrun, drain
    send(8'hA5, 1'b1);
    check("latency1_valid", out_valid, 1);
    check("latency1_count", fifo_count, 1);
    send(8'h3C, 1'b1);
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    check("full_count", fifo_count, 4);
    check("full_no_overrun", overrun, 0);
    send(8'h11, 1'b0);
    check("overrun_set",   overrun, 1);
    check("overrun_count", fifo_count, 4);
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    check("drain_count", fifo_count, 0);
    check("drain_valid", out_valid, 0);
    check("drain_data",  out_data, 0);

    // Clear the sticky overrun
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("overrun_cleared", overrun, 0);

    // Push and pop while full
    send(8'h01, 1'b1);
    send(8'h02, 1'b1);
    send(8'h03, 1'b1);
    send(8'h04, 1'b1);
    check("refill_count", fifo_count, 4);
    out_ready = 1'b1;
    send(8'h77, 1'b1);
    out_ready = 1'b0;
    check("pushpop_full_count",   fifo_count, 4);
    check("pushpop_full_overrun", overrun, 0);
    check("pushpop_head",         out_data, 8'h02);
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    check("drain2_count", fifo_count, 0);

    // Baud change: exit cycle and SETTLE pulses are ignored
    cfg_baud_select = 3'b010;
    send(8'h55, 1'b0);                 // exit cycle RUN -> LOAD
    check("rebaud_rx_en_drop", RX_EN, 0);
    check("rebaud_baud_hold",  baud_select, 3'b101);
    tick();                            // LOAD -> SETTLE
    check("rebaud_baud", baud_select, 3'b010);
    send(8'h66, 1'b0);                 // in SETTLE
    check("rebaud_settle_rx_en", RX_EN, 1'b1 ^ 1'b1);
    check("rebaud_settle_count", fifo_count, 0);
    check("rebaud_run_rx_en", RX_EN, 0);
    tick();
    check("rebaud_rx_en_back", RX_EN, 1);
    check("rebaud_no_push",    fifo_count, 0);

    // Byte with a coincident framing error is not stored
    Rx_FERROR = 1'b1;
    send(8'h99, 1'b0);
    Rx_FERROR = 1'b0;
    check("err_byte_not_pushed", fifo_count, 0);

    // Error counters (one framing error already seen above)
    Rx_FERROR = 1'b1;
    repeat (299) tick();
    Rx_FERROR = 1'b0;
    Rx_PERROR = 1'b1;
    tick();
    Rx_PERROR = 1'b0;
`ifdef UART_RXC_ERR_COUNT_EN
    check("ferr_saturated", ferr_count, 8'hFF);
    check("perr_one",       perr_count, 8'h01);
`else
    check("ferr_tied", ferr_count, 8'h00);
    check("perr_tied", perr_count, 8'h00);
`endif
    err_clear = 1'b1;
    Rx_PERROR = 1'b1;
    tick();
    err_clear = 1'b0;
    Rx_PERROR = 1'b0;
    check("perr_cleared", perr_count, 8'h00);
    check("ferr_cleared", ferr_count, 8'h00);

    // Reset with three entries buffered
    send(8'hC1, 1'b1);
    send(8'hC2, 1'b1);
    send(8'hC3, 1'b1);
    check("pre_reset_count", fifo_count, 3);
    reset = 1'b1;
    tick();
    exp_q.delete();
    check("post_reset_valid", out_valid, 0);
    check("post_reset_count", fifo_count, 0);
    check("post_reset_rx_en", RX_EN, 0);
    check("post_reset_data",  out_data, 0);
    check("post_reset_baud",  baud_select, 0);
    // IDLE is confirmed by the full four-cycle bring-up that follows.
    reset = 1'b0;
    repeat (3) tick();
    check("restart_c3_rx_en", RX_EN, 0);
    tick();
    check("restart_c4_rx_en", RX_EN, 1);
    check("restart_baud",     baud_select, 3'b010);

    tick();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
